// File: rtl/soc_addr_router_if.sv
`default_nettype none
// ****************************************************************************
// * Module   : soc_addr_router_if                                            *
// * Purpose  : Bus bundle between an upstream requester, the address router  *
// *            and the downstream peripheral fabric.                         *
// * Signals  : req_valid_i/req_ready_o/req_addr_i - upstream request         *
// *            slv_valid_o/slv_ready_i/slv_sel_o  - downstream request       *
// *            slv_rsp_valid_i                    - peripheral response      *
// *            rsp_valid_o/rsp_err_o              - upstream response        *
// *            busy_o                             - outstanding work flag    *
// * Modports : slave  - router side                                          *
// *            master - environment (requester + peripherals) side           *
// * Revision : 1.0 - initial release                                         *
// ****************************************************************************
interface soc_addr_router_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [63:0] req_addr_i;
   logic        slv_valid_o;
   logic        slv_ready_i;
   logic [3:0]  slv_sel_o;
   logic        slv_rsp_valid_i;
   logic        rsp_valid_o;
   logic        rsp_err_o;
   logic        busy_o;

   modport slave (
      input  req_valid_i, req_addr_i, slv_ready_i, slv_rsp_valid_i,
      output req_ready_o, slv_valid_o, slv_sel_o, rsp_valid_o, rsp_err_o, busy_o
   );

   modport master (
      output req_valid_i, req_addr_i, slv_ready_i, slv_rsp_valid_i,
      input  req_ready_o, slv_valid_o, slv_sel_o, rsp_valid_o, rsp_err_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/soc_addr_router.sv
`default_nettype none
// ****************************************************************************
// * Module   : soc_addr_router                                               *
// * Purpose  : Decodes a 64-bit request address onto one of twelve           *
// *            peripheral targets (or an internal decode-error target),      *
// *            limits outstanding requests and keeps responses in order by   *
// *            only admitting requests to the target already in flight.      *
// * Params   : MaxTrans      - max outstanding requests (1..15)              *
// *            ErrRspLatency - decode-error response delay in cycles (1..3)  *
// * Ports    : clk_i  - clock, rising edge                                   *
// *            rst_ni - asynchronous active-low reset                        *
// *            bus    - soc_addr_router_if.slave bundle                      *
// * Revision : 1.0 - initial release                                         *
// ****************************************************************************
module soc_addr_router #(
   parameter int unsigned MaxTrans      = 4,
   parameter int unsigned ErrRspLatency = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   soc_addr_router_if.slave bus
);

   localparam int         c_num_rules = 12;
   localparam logic [3:0] c_err_tgt   = 4'd12;
   localparam logic [3:0] c_max_trans = 4'(MaxTrans);

   // Element [k] is the rule for target index k.
   localparam logic [11:0][63:0] c_rule_base = {
      64'h0000_0000,   // 11 Debug
      64'h0001_0000,   // 10 ROM
      64'h0200_0000,   //  9 CLINT
      64'h0C00_0000,   //  8 PLIC
      64'h1000_0000,   //  7 UART
      64'h1800_0000,   //  6 Timer
      64'h2000_0000,   //  5 SPI
      64'h2400_0000,   //  4 IMSIC
      64'h3000_0000,   //  3 Ethernet
      64'h4000_0000,   //  2 GPIO
      64'h8000_0000,   //  1 DRAM
      64'h5000_0000    //  0 CLIC
   };

   localparam logic [11:0][63:0] c_rule_len = {
      64'h0000_1000,   // 11 Debug
      64'h0001_0000,   // 10 ROM
      64'h000C_0000,   //  9 CLINT
      64'h03FF_FFFF,   //  8 PLIC
      64'h0000_1000,   //  7 UART
      64'h0000_1000,   //  6 Timer
      64'h0080_0000,   //  5 SPI
      64'h0800_0000,   //  4 IMSIC
      64'h0001_0000,   //  3 Ethernet
      64'h0000_1000,   //  2 GPIO
      64'h4000_0000,   //  1 DRAM
      64'h03FF_FFFF    //  0 CLIC
   };

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic [3:0] r_cur_tgt;
   logic [3:0] w_cur_tgt_nxt;
   logic       r_rsp_pv;
   logic       w_rsp_pv_nxt;

   logic [c_num_rules-1:0] w_hit;
   logic [3:0]             w_tgt;
   logic                   w_is_err;
   logic                   w_admit;
   logic                   w_slv_valid;
   logic                   w_req_ready;
   logic [3:0]             w_slv_sel;
   logic                   w_accept;
   logic                   w_err_accept;
   logic                   w_err_out;
   logic                   w_rsp_up;

   // ------------------------------------------------------------------
   // Address decode: one comparator pair per rule. Rules are disjoint,
   // so the priority order in the encoder below never matters.
   // ------------------------------------------------------------------
   for (genvar g = 0; g < c_num_rules; g++) begin : g_rule
      assign w_hit[g] = (bus.req_addr_i >= c_rule_base[g]) &&
                        (bus.req_addr_i <  (c_rule_base[g] + c_rule_len[g]));
   end

   always_comb begin
      w_tgt = c_err_tgt;
      for (int i = 0; i < c_num_rules; i++) begin
         if (w_hit[i]) begin
            w_tgt = 4'(i);
         end
      end
   end

   // ------------------------------------------------------------------
   // Decode-error response pipeline: one bit per cycle of latency.
   // ------------------------------------------------------------------
   if (ErrRspLatency <= 1) begin : g_err_lat1
      logic r_err_pipe;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_err_pipe <= 1'b0;
         end else begin
            r_err_pipe <= w_err_accept;
         end
      end
      assign w_err_out = r_err_pipe;
   end else begin : g_err_latn
      logic [ErrRspLatency-1:0] r_err_pipe;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_err_pipe <= '0;
         end else begin
            r_err_pipe <= {r_err_pipe[ErrRspLatency-2:0], w_err_accept};
         end
      end
      assign w_err_out = r_err_pipe[ErrRspLatency-1];
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_cur_tgt <= 4'd0;
         r_rsp_pv  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_cur_tgt <= w_cur_tgt_nxt;
         r_rsp_pv  <= w_rsp_pv_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state, admission and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_is_err      = (w_tgt == c_err_tgt);
      w_slv_valid   = 1'b0;
      w_req_ready   = 1'b0;
      w_slv_sel     = 4'd0;
      w_cnt_nxt     = r_cnt;
      w_cur_tgt_nxt = r_cur_tgt;
      w_state_nxt   = r_state;

      // Only the target already in flight may be admitted, so responses
      // from different targets can never overtake one another. Gating with
      // rst_ni forces the combinational outputs low during reset.
      w_admit = rst_ni && (r_cnt < c_max_trans) &&
                ((r_state == ST_IDLE) || (w_tgt == r_cur_tgt));

      if (w_is_err) begin
         w_req_ready = w_admit;
      end else begin
         w_slv_valid = bus.req_valid_i && w_admit;
         w_req_ready = bus.slv_ready_i && w_admit;
         w_slv_sel   = rst_ni ? w_tgt : 4'd0;
      end

      w_accept     = bus.req_valid_i && w_req_ready;
      w_err_accept = w_accept && w_is_err;

      // Peripheral responses are only meaningful while a peripheral
      // target is in flight; anything else is a stray pulse.
      w_rsp_pv_nxt = bus.slv_rsp_valid_i && (r_state == ST_ACTIVE) &&
                     (r_cur_tgt != c_err_tgt);

      w_rsp_up = r_rsp_pv || w_err_out;

      case ({w_accept, w_rsp_up})
         2'b10:   w_cnt_nxt = r_cnt + 4'd1;
         2'b01:   w_cnt_nxt = (r_cnt != 4'd0) ? (r_cnt - 4'd1) : r_cnt;
         default: w_cnt_nxt = r_cnt;
      endcase

      if (w_accept) begin
         w_cur_tgt_nxt = w_tgt;
      end

      w_state_nxt = (w_cnt_nxt != 4'd0) ? ST_ACTIVE : ST_IDLE;
   end

   assign bus.slv_valid_o = w_slv_valid;
   assign bus.req_ready_o = w_req_ready;
   assign bus.slv_sel_o   = w_slv_sel;
   assign bus.rsp_valid_o = w_rsp_up;
   assign bus.rsp_err_o   = w_err_out;
   assign bus.busy_o      = (r_state == ST_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_soc_addr_router.sv
`default_nettype none
// ****************************************************************************
// * Module   : tb_soc_addr_router                                            *
// * Purpose  : Directed self-checking bench for soc_addr_router with         *
// *            MaxTrans=4, ErrRspLatency=1. Inputs change 1 time unit after  *
// *            a rising edge and outputs are sampled 1 unit later.           *
// * Revision : 1.0 - initial release                                         *
// ****************************************************************************
module tb_soc_addr_router;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

   logic [63:0] sw_base [12];
   logic [63:0] sw_len  [12];

   soc_addr_router_if bus ();

   soc_addr_router #(
      .MaxTrans      (4),
      .ErrRspLatency (1)
   ) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Idle decode probe with req_valid_i=0 and slv_ready_i=0: a peripheral
   // hit shows its index and ready=0, a miss shows sel=0 and ready=1.
   task automatic chk_dec(input string tag, input logic [63:0] addr, input logic [3:0] idx);
      tick();
      bus.req_addr_i = addr;
      settle();
      if (idx == 4'd12) begin
         chk({tag, " sel"}, 64'(bus.slv_sel_o), 64'd0);
         chk({tag, " rdy"}, 64'(bus.req_ready_o), 64'd1);
      end else begin
         chk({tag, " sel"}, 64'(bus.slv_sel_o), 64'(idx));
         chk({tag, " rdy"}, 64'(bus.req_ready_o), 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      sw_base = '{64'h5000_0000, 64'h8000_0000, 64'h4000_0000, 64'h3000_0000,
                  64'h2400_0000, 64'h2000_0000, 64'h1800_0000, 64'h1000_0000,
                  64'h0C00_0000, 64'h0200_0000, 64'h0001_0000, 64'h0000_0000};
      sw_len  = '{64'h03FF_FFFF, 64'h4000_0000, 64'h0000_1000, 64'h0001_0000,
                  64'h0800_0000, 64'h0080_0000, 64'h0000_1000, 64'h0000_1000,
                  64'h03FF_FFFF, 64'h000C_0000, 64'h0001_0000, 64'h0000_1000};

      // ---- reset: outputs low even with a valid DRAM request presented
      bus.req_valid_i     = 1'b1;
      bus.req_addr_i      = 64'h8000_0000;
      bus.slv_ready_i     = 1'b1;
      bus.slv_rsp_valid_i = 1'b0;
      #12;
      chk("rst ready",     64'(bus.req_ready_o), 64'd0);
      chk("rst slv_valid", 64'(bus.slv_valid_o), 64'd0);
      chk("rst sel",       64'(bus.slv_sel_o),   64'd0);
      chk("rst rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
      chk("rst busy",      64'(bus.busy_o),      64'd0);
      bus.req_valid_i = 1'b0;
      bus.slv_ready_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // ---- map sweep: every region end (base+len) lands in a gap
      for (int i = 0; i < 12; i++) begin
         chk_dec($sformatf("map%0d base", i), sw_base[i], 4'(i));
         chk_dec($sformatf("map%0d last", i), sw_base[i] + sw_len[i] - 64'd1, 4'(i));
         chk_dec($sformatf("map%0d end", i), sw_base[i] + sw_len[i], 4'd12);
      end
      chk_dec("map all-ones", 64'hFFFF_FFFF_FFFF_FFFF, 4'd12);
      chk_dec("map hi-bits",  64'h0000_0001_8000_0000, 4'd12);

      // ---- decode error: response one cycle after acceptance
      tick();
      bus.req_addr_i  = 64'h6000_0000;
      bus.req_valid_i = 1'b1;
      settle();
      chk("err ready",     64'(bus.req_ready_o), 64'd1);
      chk("err slv_valid", 64'(bus.slv_valid_o), 64'd0);
      tick();
      bus.req_valid_i     = 1'b0;
      bus.slv_rsp_valid_i = 1'b1;   // stray pulse while the error target is in flight
      settle();
      chk("err rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
      chk("err rsp_err",   64'(bus.rsp_err_o),   64'd1);
      chk("err busy",      64'(bus.busy_o),      64'd1);
      chk("err slv_valid2",64'(bus.slv_valid_o), 64'd0);
      tick();
      bus.slv_rsp_valid_i = 1'b1;   // stray pulse while idle
      settle();
      chk("err rsp once",  64'(bus.rsp_valid_o), 64'd0);
      chk("err busy done", 64'(bus.busy_o),      64'd0);
      tick();
      bus.slv_rsp_valid_i = 1'b0;
      settle();
      chk("stray rsp",     64'(bus.rsp_valid_o), 64'd0);
      chk("stray busy",    64'(bus.busy_o),      64'd0);

      // ---- DRAM fill to MaxTrans, fifth request stalls
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.req_addr_i  = 64'h8000_0000;
         bus.req_valid_i = 1'b1;
         bus.slv_ready_i = 1'b1;
         settle();
         chk($sformatf("dram%0d ready", i),     64'(bus.req_ready_o), 64'd1);
         chk($sformatf("dram%0d slv_valid", i), 64'(bus.slv_valid_o), 64'd1);
         chk($sformatf("dram%0d sel", i),       64'(bus.slv_sel_o),   64'd1);
      end
      tick();
      settle();
      chk("dram full ready",     64'(bus.req_ready_o), 64'd0);
      chk("dram full slv_valid", 64'(bus.slv_valid_o), 64'd0);
      chk("dram full busy",      64'(bus.busy_o),      64'd1);
      bus.slv_rsp_valid_i = 1'b1;
      tick();
      bus.slv_rsp_valid_i = 1'b0;
      settle();
      chk("dram rsp_valid",   64'(bus.rsp_valid_o), 64'd1);
      chk("dram rsp_err",     64'(bus.rsp_err_o),   64'd0);
      chk("dram still full",  64'(bus.req_ready_o), 64'd0);
      tick();
      settle();
      chk("dram slot freed",  64'(bus.req_ready_o), 64'd1);
      tick();
      bus.req_valid_i = 1'b0;
      settle();
      chk("dram refilled",    64'(bus.req_ready_o), 64'd0);
      for (int i = 0; i < 4; i++) begin
         bus.slv_rsp_valid_i = 1'b1;
         tick();
      end
      bus.slv_rsp_valid_i = 1'b0;
      settle();
      chk("dram drain rsp",  64'(bus.rsp_valid_o), 64'd1);
      chk("dram drain busy", 64'(bus.busy_o),      64'd1);
      tick();
      settle();
      chk("dram idle busy",  64'(bus.busy_o),      64'd0);
      chk("dram idle rsp",   64'(bus.rsp_valid_o), 64'd0);

      // ---- target switch: ROM waits for the UART response
      tick();
      bus.req_addr_i  = 64'h1000_0000;
      bus.req_valid_i = 1'b1;
      settle();
      chk("uart sel",   64'(bus.slv_sel_o),   64'd7);
      chk("uart ready", 64'(bus.req_ready_o), 64'd1);
      tick();
      bus.req_addr_i = 64'h0001_0000;
      settle();
      chk("rom stall ready", 64'(bus.req_ready_o), 64'd0);
      chk("rom stall valid", 64'(bus.slv_valid_o), 64'd0);
      chk("rom stall sel",   64'(bus.slv_sel_o),   64'd10);
      bus.slv_rsp_valid_i = 1'b1;
      tick();
      bus.slv_rsp_valid_i = 1'b0;
      settle();
      chk("uart rsp_valid",  64'(bus.rsp_valid_o), 64'd1);
      chk("uart rsp_err",    64'(bus.rsp_err_o),   64'd0);
      chk("rom stall2",      64'(bus.req_ready_o), 64'd0);
      tick();
      settle();
      chk("rom issue ready", 64'(bus.req_ready_o), 64'd1);
      chk("rom issue valid", 64'(bus.slv_valid_o), 64'd1);
      tick();
      bus.req_valid_i = 1'b0;
      settle();
      chk("rom busy",        64'(bus.busy_o),      64'd1);
      chk("rom no rsp yet",  64'(bus.rsp_valid_o), 64'd0);
      bus.slv_rsp_valid_i = 1'b1;
      tick();
      bus.slv_rsp_valid_i = 1'b0;
      settle();
      chk("rom rsp_valid",   64'(bus.rsp_valid_o), 64'd1);
      tick();
      settle();
      chk("rom idle busy",   64'(bus.busy_o),      64'd0);

      // ---- accept and response in the same cycle at count 2
      tick();
      bus.req_addr_i  = 64'h4000_0000;
      bus.req_valid_i = 1'b1;
      settle();
      chk("gpio0 ready", 64'(bus.req_ready_o), 64'd1);
      tick();
      settle();
      chk("gpio1 ready", 64'(bus.req_ready_o), 64'd1);
      tick();
      bus.req_valid_i = 1'b0;
      settle();
      bus.slv_rsp_valid_i = 1'b1;
      tick();
      bus.slv_rsp_valid_i = 1'b0;
      bus.req_valid_i     = 1'b1;
      settle();
      chk("simul rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
      chk("simul ready",     64'(bus.req_ready_o), 64'd1);
      tick();
      bus.req_valid_i = 1'b0;
      settle();
      chk("simul busy",      64'(bus.busy_o), 64'd1);
      bus.slv_rsp_valid_i = 1'b1;
      tick();
      settle();
      chk("simul busy cnt2", 64'(bus.busy_o), 64'd1);
      tick();
      bus.slv_rsp_valid_i = 1'b0;
      settle();
      chk("simul busy cnt1", 64'(bus.busy_o), 64'd1);
      tick();
      settle();
      chk("simul busy cnt0", 64'(bus.busy_o), 64'd0);

      // ---- reset while a decode-error response is in flight
      tick();
      bus.req_addr_i  = 64'h6000_0000;
      bus.req_valid_i = 1'b1;
      settle();
      chk("rsterr ready", 64'(bus.req_ready_o), 64'd1);
      tick();
      rst_n           = 1'b0;
      bus.req_valid_i = 1'b0;
      settle();
      chk("rsterr rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
      chk("rsterr busy",      64'(bus.busy_o),      64'd0);
      tick();
      settle();
      chk("rsterr hold rsp",  64'(bus.rsp_valid_o), 64'd0);
      @(negedge clk);
      rst_n           = 1'b1;
      bus.req_addr_i  = 64'h8000_0000;
      bus.req_valid_i = 1'b1;
      bus.slv_ready_i = 1'b1;
      settle();
      chk("post rst ready",  64'(bus.req_ready_o), 64'd1);
      chk("post rst rsp",    64'(bus.rsp_valid_o), 64'd0);
      tick();
      bus.req_valid_i = 1'b0;
      settle();
      chk("post rst busy",   64'(bus.busy_o),      64'd1);
      chk("post rst rsp2",   64'(bus.rsp_valid_o), 64'd0);
      bus.slv_rsp_valid_i = 1'b1;
      tick();
      bus.slv_rsp_valid_i = 1'b0;
      settle();
      chk("post rst dram rsp", 64'(bus.rsp_valid_o), 64'd1);
      chk("post rst dram err", 64'(bus.rsp_err_o),   64'd0);
      tick();
      settle();
      chk("post rst idle",   64'(bus.busy_o),      64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/soc_addr_router.md
SOC_ADDR_ROUTER -- requirements
Module: soc_addr_router

Interface
REQ-001 Parameter MaxTrans, default 4: maximum outstanding (accepted, not yet responded) requests, range 1..15.
REQ-002 Parameter ErrRspLatency, default 1: cycles from error-target acceptance to error response, range 1..3.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 req_valid_i  in  1 / req_ready_o  out  1  upstream request handshake; transfer when both are high.
REQ-006 req_addr_i  in  64  request byte address.
REQ-007 slv_valid_o  out  1 / slv_ready_i  in  1  downstream request handshake toward the selected peripheral.
REQ-008 slv_sel_o  out  4  target index: CLIC=0, DRAM=1, GPIO=2, Ethernet=3, IMSIC=4, SPI=5, Timer=6, UART=7, PLIC=8, CLINT=9, ROM=10, Debug=11.
REQ-009 slv_rsp_valid_i  in  1  peripheral response pulse, one per accepted peripheral request, in order.
REQ-010 rsp_valid_o  out  1 / rsp_err_o  out  1  upstream response pulse; err=1 marks an unmapped-address (decode error) response.
REQ-011 busy_o  out  1  high while the outstanding count is non-zero.

Function
REQ-012 Decode is combinational on req_addr_i; rule k hits when base_k <= addr < base_k + len_k, unsigned 64-bit compare.
REQ-013 Rules (base, len): Debug 0x0, 0x1000; ROM 0x1_0000, 0x1_0000; CLINT 0x200_0000, 0xC_0000; PLIC 0xC00_0000, 0x3FF_FFFF; UART 0x1000_0000, 0x1000; Timer 0x1800_0000, 0x1000; SPI 0x2000_0000, 0x80_0000; IMSIC 0x2400_0000, 0x800_0000; Ethernet 0x3000_0000, 0x1_0000; GPIO 0x4000_0000, 0x1000; CLIC 0x5000_0000, 0x3FF_FFFF; DRAM 0x8000_0000, 0x4000_0000.
REQ-014 No address hits two rules; an address hitting no rule selects the internal error target (index 12, never driven on slv_sel_o).
REQ-015 The block has two states: IDLE (count=0) and ACTIVE (count>0, current target latched in cur_tgt).
REQ-016 The block accepts a request only when count < MaxTrans, and either count = 0 or the decoded target equals cur_tgt. A target switch stalls until all responses drain, which preserves response order.
REQ-017 For a peripheral target: slv_valid_o = req_valid_i AND admit; req_ready_o = slv_ready_i AND admit; slv_sel_o = decoded index.
REQ-018 For the error target: slv_valid_o = 0; req_ready_o = admit; there is no downstream traffic.
REQ-019 On acceptance, count increments and cur_tgt latches the decoded target. On any upstream response, count decrements. Simultaneous accept and response leave count unchanged.
REQ-020 Error responses come from a shift pipeline of depth ErrRspLatency. Each error acceptance produces exactly one rsp_valid_o=1, rsp_err_o=1 pulse exactly ErrRspLatency cycles later.
REQ-021 For peripheral targets, rsp_valid_o = slv_rsp_valid_i registered by one cycle, with rsp_err_o = 0.
REQ-022 slv_rsp_valid_i while count = 0 or cur_tgt = error is ignored; it produces no rsp_valid_o and no count change.
REQ-023 When count = MaxTrans, req_ready_o = 0 regardless of target.
REQ-024 busy_o = (count != 0), driven from a register.

Reset
REQ-025 Asynchronous assertion of rst_ni clears count, cur_tgt, the error pipeline and the response register. All outputs go low immediately, including slv_sel_o = 0.
REQ-026 Reset mid-operation discards in-flight error responses; after release, the block is in IDLE with no spurious rsp_valid_o.
REQ-027 Deassertion is synchronous to clk_i; the first acceptance can occur on the first rising edge after release.

Verification
REQ-028 Map sweep: addr = each base, base+len-1, and base+len -> slv_sel_o matches the index for the first two; the third gives the next region's index or an error.
REQ-029 Unmapped addr 0x6000_0000 accepted at cycle t (ErrRspLatency=1) -> rsp_valid_o=1, rsp_err_o=1 at t+1; slv_valid_o stays 0.
REQ-030 Four DRAM requests back-to-back, slv_ready_i=1, no responses -> fifth request stalls (req_ready_o=0) until one slv_rsp_valid_i arrives.
REQ-031 UART request outstanding, then ROM request presented -> ROM stalls until the UART response returns, then is issued the next cycle; responses arrive in order UART, ROM.
REQ-032 Error request accepted, rst_ni pulsed low before the response -> no rsp_valid_o after reset; busy_o=0.
REQ-033 Same-cycle accept plus response at count=2 -> count stays 2; busy_o stays 1.
